// File: rtl/avalon_pkg.sv
// rtl/avalon_pkg.sv - shared response codes, burst limit and FSM states for the SRAM responder
package avalon_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam int MAX_BURST_BEATS = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RD_BURST,
      ST_WR_BURST,
      ST_WR_RESP
   } state_t;

endpackage

// File: rtl/sram_be_1rw.sv
// rtl/sram_be_1rw.sv - single-port 32-bit SRAM with byte-lane writes and registered read
module sram_be_1rw #(
   parameter int DEPTH_WORDS = 8192,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Byte-lane write and one-cycle registered read on the shared address
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
      end
      if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/avalon_burst_sram_slave.sv
// rtl/avalon_burst_sram_slave.sv - burst Avalon-MM responder over on-chip SRAM with range errors
module avalon_burst_sram_slave
   import avalon_pkg::*;
#(
   parameter logic [29:0] BASE_WADDR  = 30'h0000_0000,
   parameter int          DEPTH_WORDS = 8192,
   parameter int          MAX_BURST   = MAX_BURST_BEATS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] bus_address,
   input  logic        bus_read,
   input  logic        bus_write,
   input  logic [4:0]  bus_burstcount,
   input  logic [31:0] bus_writedata,
   input  logic [3:0]  bus_byteenable,
   output logic        s_waitrequest,
   output logic [31:0] s_readdata,
   output logic        s_readdatavalid,
   output logic [1:0]  s_response,
   output logic        s_writeresponsevalid
);

   localparam int AW = $clog2(DEPTH_WORDS);

   state_t      state, state_n;
   logic [29:0] iaddr, iaddr_n;
   logic [4:0]  cnt, cnt_n;
   logic        err, err_n;
   logic        rvld, rvld_n;
   logic        rerr, rerr_n;

   logic          ram_we, ram_re;
   logic [29:0]   ram_waddr;
   logic [AW-1:0] ram_idx;
   logic [31:0]   ram_q;

   logic       hit;
   logic       cmd_hit;
   logic [4:0] beats;

   // An address below the base wraps the 31-bit difference into its top bit
   function automatic logic in_range(input logic [29:0] a);
      logic [30:0] off;
      off = {1'b0, a} - {1'b0, BASE_WADDR};
      return !off[30] && (off < 31'(DEPTH_WORDS));
   endfunction

   function automatic logic [29:0] sat_inc(input logic [29:0] a);
      return (&a) ? a : a + 30'd1;
   endfunction

   assign hit     = in_range(bus_address);
   assign cmd_hit = hit && (bus_read || bus_write);
   assign beats   = (bus_burstcount == 5'd0)          ? 5'd1 :
                    (bus_burstcount > 5'(MAX_BURST))  ? 5'(MAX_BURST) : bus_burstcount;
   assign ram_idx = AW'(ram_waddr - BASE_WADDR);

   // Outputs stay zero unless this slave owns the beat, so they can be ORed on the bus
   assign s_waitrequest        = cmd_hit && ((state == ST_RD_BURST) || (state == ST_WR_RESP));
   assign s_readdatavalid      = rvld;
   assign s_readdata           = (rvld && !rerr) ? ram_q : 32'd0;
   assign s_writeresponsevalid = (state == ST_WR_RESP);
   assign s_response           = ((rvld && rerr) || ((state == ST_WR_RESP) && err)) ?
                                 RESP_SLVERR : RESP_OKAY;

   sram_be_1rw #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .be    (bus_byteenable),
      .addr  (ram_idx),
      .wdata (bus_writedata),
      .rdata (ram_q)
   );

   // State, burst address/counter, sticky write error and read-beat pipeline flags
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         iaddr <= 30'd0;
         cnt   <= 5'd0;
         err   <= 1'b0;
         rvld  <= 1'b0;
         rerr  <= 1'b0;
      end else begin
         state <= state_n;
         iaddr <= iaddr_n;
         cnt   <= cnt_n;
         err   <= err_n;
         rvld  <= rvld_n;
         rerr  <= rerr_n;
      end
   end

   // Command accept, per-beat SRAM access and burst sequencing
   always_comb begin
      state_n   = state;
      iaddr_n   = iaddr;
      cnt_n     = cnt;
      err_n     = err;
      rvld_n    = 1'b0;
      rerr_n    = 1'b0;
      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_waddr = iaddr;
      case (state)
         ST_IDLE: begin
            if (hit && bus_write) begin
               ram_waddr = bus_address;
               ram_we    = 1'b1;
               iaddr_n   = sat_inc(bus_address);
               cnt_n     = beats - 5'd1;
               err_n     = 1'b0;
               state_n   = (beats == 5'd1) ? ST_WR_RESP : ST_WR_BURST;
            end else if (hit && bus_read) begin
               ram_waddr = bus_address;
               ram_re    = 1'b1;
               rvld_n    = 1'b1;
               iaddr_n   = sat_inc(bus_address);
               cnt_n     = beats - 5'd1;
               state_n   = ST_RD_BURST;
            end
         end
         ST_RD_BURST: begin
            if (cnt != 5'd0) begin
               ram_re  = 1'b1;
               rvld_n  = 1'b1;
               rerr_n  = !in_range(iaddr);
               iaddr_n = sat_inc(iaddr);
               cnt_n   = cnt - 5'd1;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_WR_BURST: begin
            if (bus_write) begin
               if (in_range(iaddr)) begin
                  ram_we = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
               iaddr_n = sat_inc(iaddr);
               cnt_n   = cnt - 5'd1;
               if (cnt == 5'd1) begin
                  state_n = ST_WR_RESP;
               end
            end
         end
         ST_WR_RESP: begin
            state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_avalon_burst_sram_slave.sv
// tb/tb_avalon_burst_sram_slave.sv - scoreboard bench for the burst SRAM responder
module tb_avalon_burst_sram_slave;

   localparam logic [29:0] BASE  = 30'h40;
   localparam int          DEPTH = 64;
   localparam int          MAXB  = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [29:0] bus_address;
   logic        bus_read;
   logic        bus_write;
   logic [4:0]  bus_burstcount;
   logic [31:0] bus_writedata;
   logic [3:0]  bus_byteenable;
   logic        s_waitrequest;
   logic [31:0] s_readdata;
   logic        s_readdatavalid;
   logic [1:0]  s_response;
   logic        s_writeresponsevalid;

   avalon_burst_sram_slave #(
      .BASE_WADDR(BASE), .DEPTH_WORDS(DEPTH), .MAX_BURST(MAXB)
   ) dut (
      .clk(clk), .rst(rst), .bus_address(bus_address), .bus_read(bus_read),
      .bus_write(bus_write), .bus_burstcount(bus_burstcount), .bus_writedata(bus_writedata),
      .bus_byteenable(bus_byteenable), .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .s_readdatavalid(s_readdatavalid), .s_response(s_response),
      .s_writeresponsevalid(s_writeresponsevalid)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] data; logic [1:0] resp; int cyc; } rd_exp_t;
   typedef struct { logic [1:0] resp; int cyc; } wr_exp_t;

   rd_exp_t     rd_q[$];
   wr_exp_t     wr_q[$];
   logic [31:0] model [DEPTH];
   logic [31:0] wdat [MAXB];
   logic [3:0]  wbe [MAXB];
   int          n_tests = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          free_cyc = 0;
   int          bubble_before = -1;
   bit          rnd_bubbles = 0;
   bit          mon_en = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit tb_hit(input longint a);
      return (a >= longint'(BASE)) && (a < longint'(BASE) + DEPTH);
   endfunction

   function automatic int n_beats(input int bc);
      if (bc == 0) return 1;
      if (bc > MAXB) return MAXB;
      return bc;
   endfunction

   // Monitor: every visible strobe must match the oldest expectation, in the predicted cycle
   always @(negedge clk) begin
      if (mon_en) begin
         if (s_readdatavalid) begin
            if (rd_q.size() == 0) begin
               check("unexpected_read_beat", 1, 0);
            end else begin
               rd_exp_t e;
               e = rd_q.pop_front();
               check("rd_data", s_readdata, e.data);
               check("rd_resp", s_response, e.resp);
               check("rd_cycle", cyc, e.cyc);
            end
         end else begin
            check("rdata_idle_zero", s_readdata, 0);
         end
         if (s_writeresponsevalid) begin
            if (wr_q.size() == 0) begin
               check("unexpected_write_resp", 1, 0);
            end else begin
               wr_exp_t w;
               w = wr_q.pop_front();
               check("wr_resp", s_response, w.resp);
               check("wr_cycle", cyc, w.cyc);
            end
         end
         if (!s_readdatavalid && !s_writeresponsevalid) begin
            check("resp_idle_zero", s_response, 0);
         end
      end
   end

   task automatic wait_accept(output int acc);
      int guard;
      guard = 0;
      @(negedge clk);
      while (s_waitrequest === 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 200) check("accept_timeout", 1, 0);
      acc = cyc;
      @(posedge clk); #1;
   endtask

   task automatic present_miss(input longint a, input bit wr);
      bus_address = 30'(a);
      bus_read = !wr;
      bus_write = wr;
      bus_burstcount = 5'd1;
      @(negedge clk);
      check("miss_no_wait", s_waitrequest, 0);
      @(posedge clk); #1;
      bus_read = 1'b0;
      bus_write = 1'b0;
   endtask

   task automatic do_read(input int off, input int bc);
      longint a;
      int n, acc, pres;
      a = longint'(BASE) + off;
      if (!tb_hit(a)) begin
         present_miss(a, 1'b0);
         return;
      end
      n = n_beats(bc);
      bus_address = 30'(a);
      bus_burstcount = 5'(bc);
      bus_byteenable = 4'($urandom_range(0, 15));
      bus_read = 1'b1;
      pres = cyc;
      wait_accept(acc);
      check("rd_accept_cycle", acc, (pres > free_cyc) ? pres : free_cyc);
      bus_read = 1'b0;
      for (int k = 0; k < n; k++) begin
         rd_exp_t e;
         if (tb_hit(a + k)) begin
            e.data = model[int'(a + k - longint'(BASE))];
            e.resp = 2'b00;
         end else begin
            e.data = 32'd0;
            e.resp = 2'b10;
         end
         e.cyc = acc + k + 1;
         rd_q.push_back(e);
      end
      free_cyc = acc + n + 1;
   endtask

   task automatic model_write(input longint a, input logic [31:0] d, input logic [3:0] be);
      int idx;
      idx = int'(a - longint'(BASE));
      for (int i = 0; i < 4; i++) begin
         if (be[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      end
   endtask

   task automatic do_write(input int off, input int bc);
      longint a;
      int n, acc, pres, last, nb;
      bit err;
      wr_exp_t w;
      a = longint'(BASE) + off;
      if (!tb_hit(a)) begin
         present_miss(a, 1'b1);
         return;
      end
      n = n_beats(bc);
      err = 0;
      bus_address = 30'(a);
      bus_burstcount = 5'(bc);
      bus_writedata = wdat[0];
      bus_byteenable = wbe[0];
      bus_write = 1'b1;
      pres = cyc;
      wait_accept(acc);
      check("wr_accept_cycle", acc, (pres > free_cyc) ? pres : free_cyc);
      model_write(a, wdat[0], wbe[0]);
      last = acc;
      for (int k = 1; k < n; k++) begin
         nb = (k == bubble_before) ? 1 : (rnd_bubbles ? $urandom_range(0, 1) : 0);
         bus_write = 1'b0;
         bus_burstcount = 5'($urandom_range(0, 31));
         repeat (nb) begin
            @(posedge clk); #1;
         end
         bus_write = 1'b1;
         bus_writedata = wdat[k];
         bus_byteenable = wbe[k];
         @(negedge clk);
         check("wr_burst_no_wait", s_waitrequest, 0);
         last = cyc;
         @(posedge clk); #1;
         if (tb_hit(a + k)) model_write(a + k, wdat[k], wbe[k]);
         else err = 1;
      end
      bus_write = 1'b0;
      w.resp = err ? 2'b10 : 2'b00;
      w.cyc = last + 1;
      wr_q.push_back(w);
      free_cyc = last + 2;
   endtask

   task automatic idle_cycles(input int c);
      repeat (c) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      rst = 1'b1;
      bus_address = '0; bus_read = 1'b0; bus_write = 1'b0; bus_burstcount = '0;
      bus_writedata = '0; bus_byteenable = '0;
      idle_cycles(3);
      @(negedge clk);
      check("reset_waitrequest", s_waitrequest, 0);
      check("reset_readdata", s_readdata, 0);
      check("reset_readdatavalid", s_readdatavalid, 0);
      check("reset_response", s_response, 0);
      check("reset_writeresponsevalid", s_writeresponsevalid, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      free_cyc = cyc;
      mon_en = 1;

      for (int blk = 0; blk < DEPTH / 16; blk++) begin
         for (int k = 0; k < 16; k++) begin
            wdat[k] = 32'(blk * 16 + k);
            wbe[k] = 4'hF;
         end
         do_write(blk * 16, 16);
      end
      do_read(0, 16);
      do_read(0, 16);

      wdat[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
      do_write(4, 1);
      do_read(4, 1);

      wdat[0] = 32'hAAAA_0001; wdat[1] = 32'hBBBB_0002;
      wdat[2] = 32'hCCCC_0003; wdat[3] = 32'hDDDD_0004;
      for (int k = 0; k < 4; k++) wbe[k] = 4'hF;
      bubble_before = 2;
      do_write(8, 4);
      bubble_before = -1;
      do_read(8, 4);

      wdat[0] = 32'hFFFF_FFFF; wbe[0] = 4'hF;
      do_write(20, 1);
      wdat[0] = 32'h1122_3344; wbe[0] = 4'b0101;
      do_write(20, 1);
      do_read(20, 1);

      do_read(DEPTH - 2, 4);
      for (int k = 0; k < 4; k++) begin
         wdat[k] = $urandom; wbe[k] = 4'hF;
      end
      do_write(DEPTH - 2, 4);
      do_read(DEPTH - 2, 2);

      do_read(30, 0);
      do_read(30, 31);
      do_read(-2, 1);
      do_read(DEPTH + 1, 1);
      do_write(DEPTH, 2);
      idle_cycles(2);

      bus_address = BASE;
      bus_burstcount = 5'd16;
      bus_read = 1'b1;
      wait_accept(acc);
      check("rst_test_accept", acc, (acc > free_cyc) ? acc : free_cyc);
      bus_read = 1'b0;
      for (int k = 0; k < 5; k++) begin
         rd_exp_t e;
         e.data = model[k]; e.resp = 2'b00; e.cyc = acc + k + 1;
         rd_q.push_back(e);
      end
      while (cyc < acc + 5) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_readdatavalid", s_readdatavalid, 0);
      check("post_rst_readdata", s_readdata, 0);
      check("post_rst_response", s_response, 0);
      check("post_rst_writeresponsevalid", s_writeresponsevalid, 0);
      check("post_rst_waitrequest", s_waitrequest, 0);
      @(posedge clk); #1;
      idle_cycles(20);
      free_cyc = cyc;
      do_read(3, 4);

      rnd_bubbles = 1;
      for (int t = 0; t < 60; t++) begin
         int off, bc;
         off = $urandom_range(0, DEPTH + 8) - 4;
         bc = $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) begin
            for (int k = 0; k < MAXB; k++) begin
               wdat[k] = $urandom;
               wbe[k] = 4'($urandom_range(0, 15));
            end
            do_write(off, bc);
         end else begin
            do_read(off, bc);
         end
         idle_cycles($urandom_range(0, 2));
      end

      idle_cycles(40);
      check("rd_queue_drained", rd_q.size(), 0);
      check("wr_queue_drained", wr_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
